// File: rtl/rename_unit.sv
// Register rename stage: speculative/committed RATs plus a circular free list.
// Ports: decode in_* (valid/ready), renamed out_*, ROB ret_*, flush, fl_count.
module rename_unit #(
    parameter  int ARCH_REGS = 32,
    parameter  int PHYS_REGS = 64,
    localparam int AREG_W    = $clog2(ARCH_REGS),
    localparam int PREG_W    = $clog2(PHYS_REGS)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AREG_W-1:0] in_rs1,
    input  logic [AREG_W-1:0] in_rs2,
    input  logic [AREG_W-1:0] in_rd,
    input  logic              in_rd_wr,
    output logic              out_valid,
    output logic [PREG_W-1:0] out_ps1,
    output logic [PREG_W-1:0] out_ps2,
    output logic [PREG_W-1:0] out_pd,
    output logic [PREG_W-1:0] out_pd_old,
    output logic              out_pd_alloc,
    input  logic              ret_valid,
    input  logic [AREG_W-1:0] ret_rd,
    input  logic [PREG_W-1:0] ret_pd,
    input  logic [PREG_W-1:0] ret_pd_old,
    input  logic              flush,
    output logic [PREG_W:0]   fl_count
);

    localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int FL_W     = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
    localparam int CNT_W    = PREG_W + 1;

    typedef struct packed {
        logic            wrap;
        logic [FL_W-1:0] idx;
    } ptr_t;

    // Explicit wrap keeps the pointers correct for non power-of-2 depths.
    function automatic ptr_t inc(input ptr_t p);
        ptr_t r;
        if (p.idx == FL_W'(FL_DEPTH - 1)) begin
            r.idx  = '0;
            r.wrap = ~p.wrap;
        end else begin
            r.idx  = p.idx + 1'b1;
            r.wrap = p.wrap;
        end
        return r;
    endfunction

    logic [PREG_W-1:0] rat  [ARCH_REGS];
    logic [PREG_W-1:0] crat [ARCH_REGS];
    logic [PREG_W-1:0] fl   [FL_DEPTH];
    ptr_t head, tail, commit_head;

    logic fl_full, accept, alloc, ret_ok;
    ptr_t commit_nxt;

    always_comb begin
        if (head.wrap == tail.wrap)
            fl_count = CNT_W'(tail.idx) - CNT_W'(head.idx);
        else
            fl_count = CNT_W'(FL_DEPTH) + CNT_W'(tail.idx)
                     - CNT_W'(head.idx);
    end

    assign fl_full    = (fl_count == CNT_W'(FL_DEPTH));
    assign in_ready   = (fl_count != '0) && !flush;
    assign accept     = in_valid && in_ready;
    assign alloc      = accept && in_rd_wr && (in_rd != '0);
    assign ret_ok     = ret_valid && !fl_full;
    assign commit_nxt = ret_ok ? inc(commit_head) : commit_head;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat[i]  <= PREG_W'(i);
                crat[i] <= PREG_W'(i);
            end
            for (int k = 0; k < FL_DEPTH; k++)
                fl[k] <= PREG_W'(ARCH_REGS + k);
            head         <= '0;
            commit_head  <= '0;
            // Wrap bit set so the list reads as full out of reset.
            tail         <= '{wrap: 1'b1, idx: '0};
            out_valid    <= 1'b0;
            out_ps1      <= '0;
            out_ps2      <= '0;
            out_pd       <= '0;
            out_pd_old   <= '0;
            out_pd_alloc <= 1'b0;
        end else begin
            if (ret_ok) begin
                fl[tail.idx] <= ret_pd_old;
                tail         <= inc(tail);
                commit_head  <= commit_nxt;
                if (ret_rd != '0)
                    crat[ret_rd] <= ret_pd;
            end
            if (flush) begin
                // Restore includes this cycle's retire.
                for (int i = 1; i < ARCH_REGS; i++)
                    rat[i] <= (ret_ok && ret_rd == AREG_W'(i))
                            ? ret_pd : crat[i];
                head      <= commit_nxt;
                out_valid <= 1'b0;
            end else begin
                out_valid <= accept;
                if (accept) begin
                    out_ps1      <= rat[in_rs1];
                    out_ps2      <= rat[in_rs2];
                    out_pd_old   <= rat[in_rd];
                    out_pd       <= alloc ? fl[head.idx] : rat[in_rd];
                    out_pd_alloc <= alloc;
                end
                if (alloc) begin
                    rat[in_rd] <= fl[head.idx];
                    head       <= inc(head);
                end
            end
        end
    end

    ret_not_full: assert property (
        @(posedge clk) disable iff (!rstn) !(ret_valid && fl_full)
    );

endmodule

// File: tb/tb_rename_unit.sv
// Scoreboard bench for rename_unit: directed renames, retires, flushes.
// Expected outputs queued at issue, compared by a negedge monitor.
module tb_rename_unit;

    localparam int AREG_W = 5;
    localparam int PREG_W = 6;

    typedef struct {
        logic [PREG_W-1:0] ps1, ps2, pd, old;
        logic              alloc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              in_valid = 1'b0, in_ready, in_rd_wr = 1'b0;
    logic [AREG_W-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic              out_valid, out_pd_alloc;
    logic [PREG_W-1:0] out_ps1, out_ps2, out_pd, out_pd_old;
    logic              ret_valid = 1'b0, flush = 1'b0;
    logic [AREG_W-1:0] ret_rd = '0;
    logic [PREG_W-1:0] ret_pd = '0, ret_pd_old = '0;
    logic [PREG_W:0]   fl_count;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    rename_unit dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rd(in_rd), .in_rd_wr(in_rd_wr),
        .out_valid(out_valid), .out_ps1(out_ps1),
        .out_ps2(out_ps2), .out_pd(out_pd),
        .out_pd_old(out_pd_old), .out_pd_alloc(out_pd_alloc),
        .ret_valid(ret_valid), .ret_rd(ret_rd),
        .ret_pd(ret_pd), .ret_pd_old(ret_pd_old),
        .flush(flush), .fl_count(fl_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (rstn && out_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: pd=%0d, none expected",
                         out_pd);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (out_ps1 !== e.ps1 || out_ps2 !== e.ps2 ||
                    out_pd !== e.pd || out_pd_old !== e.old ||
                    out_pd_alloc !== e.alloc) begin
                    errors++;
                    $display("FAIL rename_out: got %0d/%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d/%0d",
                             out_ps1, out_ps2, out_pd, out_pd_old,
                             out_pd_alloc, e.ps1, e.ps2, e.pd, e.old,
                             e.alloc);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    task automatic expect_out(input int ps1, input int ps2,
                              input int pd, input int old,
                              input int al);
        exp_t e;
        e.ps1   = PREG_W'(ps1);
        e.ps2   = PREG_W'(ps2);
        e.pd    = PREG_W'(pd);
        e.old   = PREG_W'(old);
        e.alloc = al[0];
        q.push_back(e);
    endtask

    task automatic set_in(input logic v, input int rs1, input int rs2,
                          input int rd, input logic wr, input logic rv,
                          input int rrd, input int rpd, input int rold,
                          input logic fl);
        in_valid   = v;
        in_rs1     = AREG_W'(rs1);
        in_rs2     = AREG_W'(rs2);
        in_rd      = AREG_W'(rd);
        in_rd_wr   = wr;
        ret_valid  = rv;
        ret_rd     = AREG_W'(rrd);
        ret_pd     = PREG_W'(rpd);
        ret_pd_old = PREG_W'(rold);
        flush      = fl;
    endtask

    task automatic clear_in();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cyc(input logic v, input int rs1, input int rs2,
                       input int rd, input logic wr, input logic rv,
                       input int rrd, input int rpd, input int rold,
                       input logic fl);
        set_in(v, rs1, rs2, rd, wr, rv, rrd, rpd, rold, fl);
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic ren(input int rs1, input int rs2, input int rd,
                       input logic wr);
        cyc(1, rs1, rs2, rd, wr, 0, 0, 0, 0, 0);
    endtask

    task automatic ret(input int rrd, input int rpd, input int rold);
        cyc(0, 0, 0, 0, 0, 1, rrd, rpd, rold, 0);
    endtask

    task automatic do_reset();
        clear_in();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        chk("queue_drained", q.size(), 0);
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_fl_count", int'(fl_count), 32);
        chk("rst_out_pd", int'(out_pd), 0);
    endtask

    initial begin
        // 1: basic allocation chain on rd=5
        do_reset();
        expect_out(3, 4, 32, 5, 1);
        ren(3, 4, 5, 1);
        expect_out(3, 4, 33, 32, 1);
        ren(3, 4, 5, 1);
        chk("t1_fl_count", int'(fl_count), 30);

        // 2: x0 and non-writing instructions allocate nothing
        do_reset();
        expect_out(1, 2, 0, 0, 0);
        ren(1, 2, 0, 1);
        expect_out(7, 7, 7, 7, 0);
        ren(7, 7, 7, 0);
        chk("t2_fl_count", int'(fl_count), 32);

        // 3: drain the free list, stall, then refill by retire
        do_reset();
        for (int i = 0; i < 32; i++) begin
            int rd;
            rd = (i % 31) + 1;
            expect_out(0, 0, 32 + i, (i < 31) ? rd : 32, 1);
            ren(0, 0, rd, 1);
        end
        chk("t3_empty_count", int'(fl_count), 0);
        chk("t3_empty_ready", int'(in_ready), 0);
        set_in(1, 0, 0, 2, 1, 1, 1, 32, 1, 0);
        #1;
        chk("t3_stall_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        ret_valid = 1'b0;
        chk("t3_freed_count", int'(fl_count), 1);
        chk("t3_freed_ready", int'(in_ready), 1);
        expect_out(0, 0, 1, 33, 1);
        @(posedge clk);
        #1;
        clear_in();
        chk("t3_reuse_count", int'(fl_count), 0);

        // 4: alloc and retire in the same cycle at fl_count=1
        ret(2, 33, 2);
        chk("t4_count_pre", int'(fl_count), 1);
        expect_out(0, 0, 2, 34, 1);
        cyc(1, 0, 0, 3, 1, 1, 3, 34, 3, 0);
        chk("t4_count_same", int'(fl_count), 1);
        expect_out(0, 0, 3, 35, 1);
        ren(0, 0, 4, 1);
        chk("t4_count_post", int'(fl_count), 0);

        // 5: flush restores committed mapping, reclaims un-retired regs
        do_reset();
        expect_out(0, 0, 32, 5, 1);
        ren(0, 0, 5, 1);
        expect_out(0, 0, 33, 6, 1);
        ren(0, 0, 6, 1);
        ret(5, 32, 5);
        chk("t5_count_ret", int'(fl_count), 31);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("t5_count_flush", int'(fl_count), 32);
        expect_out(32, 6, 0, 0, 0);
        ren(5, 6, 0, 0);
        expect_out(0, 0, 33, 7, 1);
        ren(0, 0, 7, 1);

        // 6: flush with in_valid and concurrent retire
        do_reset();
        expect_out(0, 0, 32, 5, 1);
        ren(0, 0, 5, 1);
        expect_out(0, 0, 33, 6, 1);
        ren(0, 0, 6, 1);
        expect_out(0, 0, 34, 7, 1);
        ren(0, 0, 7, 1);
        set_in(1, 0, 0, 8, 1, 1, 5, 32, 5, 1);
        #1;
        chk("t6_flush_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        clear_in();
        chk("t6_flush_valid", int'(out_valid), 0);
        chk("t6_flush_count", int'(fl_count), 32);
        expect_out(32, 6, 7, 7, 0);
        ren(5, 6, 7, 0);
        expect_out(0, 0, 33, 8, 1);
        ren(0, 0, 8, 1);

        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("final_queue", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
